fifo_resultados_mm: RTL and testbench
=====================================

FIFO_RESULTADOS_MM -- requirements
Module: fifo_resultados_mm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stored word width (1..32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, giving a depth of 2**DEPTH_LOG2 words.
REQ-003 SHALL have parameter AFULL_LVL, default 1008, the almost-full threshold in words.
REQ-004 SHALL have port wrclock, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port avalonst_sink_data, input, DATA_W bits: data to push.
REQ-007 SHALL have port avalonst_sink_valid, input, 1 bit: push request.
REQ-008 SHALL have port avalonst_sink_ready, output, 1 bit: high when a push is accepted (not full, not flushing).
REQ-009 SHALL have port avalonmm_read_slave_address, input, 2 bits: register select.
REQ-010 SHALL have port avalonmm_read_slave_read, input, 1 bit: read strobe.
REQ-011 SHALL have port avalonmm_read_slave_write, input, 1 bit: write strobe.
REQ-012 SHALL have port avalonmm_read_slave_writedata, input, 32 bits: control write data.
REQ-013 SHALL have port avalonmm_read_slave_readdata, output, 32 bits: registered read data.

Function
REQ-014 SHALL push sink_data when sink_valid and sink_ready are both high on a rising edge; sink_ready = !full & !flush_pending.
REQ-015 SHALL drop a push attempted while full and set sticky flag OVF.
REQ-016 SHALL map registers as: addr0 DATA (a read pops), addr1 LEVEL, addr2 STATUS, addr3 CONTROL (write only; reads return 0).
REQ-017 SHALL give all reads a fixed latency of 1: readdata is updated on the edge after the read strobe, and holds its value otherwise.
REQ-018 SHALL, on a DATA read while not empty, return the head word zero-extended to 32 bits and advance the read pointer.
REQ-019 SHALL, on a DATA read while empty, return 0, leave the pointers unchanged and set sticky flag UNF.
REQ-020 SHALL return LEVEL as the occupancy count, DEPTH_LOG2+1 bits wide, zero-extended, ranging 0..2**DEPTH_LOG2.
REQ-021 SHALL return STATUS as: bit0 empty, bit1 full, bit2 almost_full (level >= AFULL_LVL), bit3 OVF, bit4 UNF, bit5 IRQ_ENA; other bits 0.
REQ-022 SHALL, on a simultaneous push and pop with the FIFO neither empty nor full, perform both and leave the level unchanged.
REQ-023 SHALL, on a simultaneous push and DATA read while empty, return 0, set UNF and store the pushed word (level becomes 1).
REQ-024 SHALL, on a simultaneous push and pop while full, perform the pop only, drop the push and set OVF.
REQ-025 SHALL wrap both pointers modulo 2**DEPTH_LOG2.
REQ-026 SHALL act on a CONTROL write as follows: bit0 flush, bit1 clear OVF and UNF, bit2 loads IRQ_ENA.
REQ-027 SHALL, on flush, zero the pointers and level on the next edge, hold sink_ready low for that cycle and ignore any concurrent push.
REQ-028 SHALL give a set event priority over a clear when both hit a sticky flag in the same cycle.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear: pointers, level, OVF, UNF, IRQ_ENA and readdata (to 0); sink_ready is 0 during reset.
REQ-030 SHALL discard all buffered data on a mid-operation reset; RAM contents are don't-care.
REQ-031 SHALL raise sink_ready on the first edge after reset_n is released.

Configuration
REQ-032 SHALL, with FIFO_RESULTADOS_IRQ_EN defined, add output port irq (1 bit, registered) = IRQ_ENA & (almost_full | OVF), cleared by reset.
REQ-033 SHALL, without FIFO_RESULTADOS_IRQ_EN, have no irq port, ignore CONTROL bit2 and read STATUS bit5 as 0.

Verification
REQ-034 SHALL cover: push 0x11,0x22,0x33, then 3 DATA reads -> readdata 0x11,0x22,0x33, each one cycle after its read; LEVEL 0; STATUS bit0=1.
REQ-035 SHALL cover: DEPTH_LOG2=4, push 17 words -> sink_ready low after the 16th, the 17th dropped, STATUS = 0x0E (full, afull, OVF), LEVEL 16.
REQ-036 SHALL cover: DATA read on an empty FIFO -> readdata 0, STATUS bit4=1; then CONTROL write 0x2 -> STATUS bit4=0.
REQ-037 SHALL cover: level 5 with push and pop in the same cycle for 20 cycles -> LEVEL stays 5, data order is preserved across pointer wrap.
REQ-038 SHALL cover: level 8, CONTROL write 0x1 plus a concurrent push -> LEVEL 0, empty=1, the push is lost.
REQ-039 SHALL cover, with FIFO_RESULTADOS_IRQ_EN, DEPTH_LOG2=4, AFULL_LVL=12: CONTROL 0x4, push 12 words -> irq rises one cycle after level reaches 12; reset_n low mid-stream -> irq and LEVEL 0 immediately.

Source files
------------

// File: rtl/fifo_resultados_mm.sv
// Result FIFO: Avalon-ST sink in, Avalon-MM read slave out (DATA/LEVEL/STATUS/CONTROL).
// Optional registered irq output enabled by defining FIFO_RESULTADOS_IRQ_EN.
module fifo_resultados_mm #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int AFULL_LVL  = 1008
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] avalonst_sink_data,
  input  logic              avalonst_sink_valid,
  output logic              avalonst_sink_ready,
  input  logic [1:0]        avalonmm_read_slave_address,
  input  logic              avalonmm_read_slave_read,
  input  logic              avalonmm_read_slave_write,
  input  logic [31:0]       avalonmm_read_slave_writedata,
  output logic [31:0]       avalonmm_read_slave_readdata
`ifdef FIFO_RESULTADOS_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_LEVEL   = 2'd1,
    ADDR_STATUS  = 2'd2,
    ADDR_CONTROL = 2'd3
  } reg_addr_e;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  ovf, unf, irq_ena, ready_en;
  logic                  empty, full, afull;
  logic                  ctrl_wr, flush, clr_flags, data_rd, push, pop;
  logic [31:0]           rd_mux;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));
  assign afull = (32'(level) >= 32'(AFULL_LVL));

  assign ctrl_wr   = avalonmm_read_slave_write && (avalonmm_read_slave_address == ADDR_CONTROL);
  assign flush     = ctrl_wr && avalonmm_read_slave_writedata[0];
  assign clr_flags = ctrl_wr && avalonmm_read_slave_writedata[1];
  assign data_rd   = avalonmm_read_slave_read && (avalonmm_read_slave_address == ADDR_DATA);

  // ready_en keeps the sink stalled during reset and until the first edge after release.
  assign avalonst_sink_ready = ready_en && !full && !flush;
  assign push = avalonst_sink_valid && avalonst_sink_ready;
  assign pop  = data_rd && !empty;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    unique case (avalonmm_read_slave_address)
      ADDR_DATA:    rd_mux = empty ? 32'd0 : 32'(mem[rd_ptr]);
      ADDR_LEVEL:   rd_mux = 32'(level);
      ADDR_STATUS:  rd_mux = 32'({irq_ena, unf, ovf, afull, full, empty});
      ADDR_CONTROL: rd_mux = 32'd0;
      default:      rd_mux = 32'd0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr                       <= '0;
      rd_ptr                       <= '0;
      level                        <= '0;
      ovf                          <= 1'b0;
      unf                          <= 1'b0;
      ready_en                     <= 1'b0;
      avalonmm_read_slave_readdata <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
      end
      // Set events win over a concurrent clear.
      ovf <= (avalonst_sink_valid && full && !flush) || (ovf && !clr_flags);
      unf <= (data_rd && empty) || (unf && !clr_flags);
      if (avalonmm_read_slave_read) avalonmm_read_slave_readdata <= rd_mux;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge wrclock) begin
    if (push) mem[wr_ptr] <= avalonst_sink_data;
  end

`ifdef FIFO_RESULTADOS_IRQ_EN
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      irq_ena <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (ctrl_wr) irq_ena <= avalonmm_read_slave_writedata[2];
      irq <= irq_ena && (afull || ovf);
    end
  end
`else
  assign irq_ena = 1'b0;
  logic unused_irq_bit;
  assign unused_irq_bit = avalonmm_read_slave_writedata[2];
`endif

  logic unused_wdata;
  assign unused_wdata = ^avalonmm_read_slave_writedata[31:3];

endmodule

// File: tb/tb_fifo_resultados_mm.sv
// Directed bench for fifo_resultados_mm (DEPTH_LOG2=4, AFULL_LVL=12, DATA_W=16).
// Define FIFO_RESULTADOS_IRQ_EN to also exercise the irq output.
module tb_fifo_resultados_mm;

  localparam int DW = 16;

  logic          wrclock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] sink_data;
  logic          sink_valid;
  logic          sink_ready;
  logic [1:0]    mm_addr;
  logic          mm_read;
  logic          mm_write;
  logic [31:0]   mm_wdata;
  logic [31:0]   mm_rdata;
`ifdef FIFO_RESULTADOS_IRQ_EN
  logic          irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fifo_resultados_mm #(.DATA_W(DW), .DEPTH_LOG2(4), .AFULL_LVL(12)) dut (
    .wrclock                       (wrclock),
    .reset_n                       (reset_n),
    .avalonst_sink_data            (sink_data),
    .avalonst_sink_valid           (sink_valid),
    .avalonst_sink_ready           (sink_ready),
    .avalonmm_read_slave_address   (mm_addr),
    .avalonmm_read_slave_read      (mm_read),
    .avalonmm_read_slave_write     (mm_write),
    .avalonmm_read_slave_writedata (mm_wdata),
    .avalonmm_read_slave_readdata  (mm_rdata)
`ifdef FIFO_RESULTADOS_IRQ_EN
    ,
    .irq                           (irq)
`endif
  );

  always #5 wrclock = ~wrclock;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          push;
    logic [DW-1:0] din;
    logic          rd;
    logic          wr;
    logic [1:0]    addr;
    logic [31:0]   wdata;
    logic          chk;
    logic [31:0]   exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge wrclock);
    @(negedge wrclock);
  endtask

  task automatic idle_inputs();
    sink_valid = 1'b0;
    sink_data  = '0;
    mm_read    = 1'b0;
    mm_write   = 1'b0;
    mm_addr    = 2'd0;
    mm_wdata   = '0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    sink_valid = 1'b1;
    sink_data  = d;
    tick();
    sink_valid = 1'b0;
  endtask

  task automatic mm_rd(input logic [1:0] a, output logic [31:0] q);
    mm_read = 1'b1;
    mm_addr = a;
    tick();
    mm_read = 1'b0;
    q = mm_rdata;
  endtask

  task automatic mm_wr(input logic [31:0] d);
    mm_write = 1'b1;
    mm_addr  = 2'd3;
    mm_wdata = d;
    tick();
    mm_write = 1'b0;
  endtask

  function automatic vec_t mk(input logic p, input logic [DW-1:0] d, input logic r, input logic w,
                              input logic [1:0] a, input logic [31:0] wd, input logic c,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.push = p; v.din = d; v.rd = r; v.wr = w; v.addr = a; v.wdata = wd;
    v.chk = c; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic run_vectors();
    foreach (vecs[i]) begin
      sink_valid = vecs[i].push;
      sink_data  = vecs[i].din;
      mm_read    = vecs[i].rd;
      mm_write   = vecs[i].wr;
      mm_addr    = vecs[i].addr;
      mm_wdata   = vecs[i].wdata;
      tick();
      if (vecs[i].chk) check(vecs[i].name, mm_rdata, vecs[i].exp);
    end
    idle_inputs();
  endtask

  logic [31:0] q;

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    // Reset state
    #23;
    check("reset_ready", 32'(sink_ready), 32'd0);
    check("reset_rdata", mm_rdata, 32'd0);
    @(negedge wrclock);
    reset_n = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(sink_ready), 32'd0);
    tick();
    check("ready_after_first_edge", 32'(sink_ready), 32'd1);

    // Basic order, register map, underflow, flag clear, push+read on empty
    vecs.push_back(mk(1, 16'h0011, 0, 0, 2'd0, 0, 0, 0, ""));
    vecs.push_back(mk(1, 16'h0022, 0, 0, 2'd0, 0, 0, 0, ""));
    vecs.push_back(mk(1, 16'h0033, 0, 0, 2'd0, 0, 0, 0, ""));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 0, 1, 32'd3,    "level_3"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 1, 32'h11,   "data_0x11"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 1, 32'h22,   "data_0x22"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 1, 32'h33,   "data_0x33"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 0, 1, 32'd0,    "level_0"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 0, 1, 32'h01,   "status_empty"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 1, 32'd0,    "data_empty_zero"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 0, 1, 32'h11,   "status_unf"));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 0, 1, 32'h11,   "rdata_holds"));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3, 32'h2, 0, 0, ""));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 0, 1, 32'h01,   "status_unf_cleared"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd3, 0, 1, 32'd0,    "control_reads_0"));
    vecs.push_back(mk(1, 16'h0044, 1, 0, 2'd0, 0, 1, 32'd0, "push_read_empty"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd2, 0, 1, 32'h10,   "status_unf_not_empty"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 0, 1, 32'd1,    "level_1_after_push_read"));
    vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 1, 32'h44,   "data_0x44"));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3, 32'h2, 0, 0, ""));
    run_vectors();

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ready_fill_%0d", i), 32'(sink_ready), 32'd1);
      push(DW'(16'h0100 + i));
    end
    check("ready_low_when_full", 32'(sink_ready), 32'd0);
    push(16'h01FF);
    mm_rd(2'd1, q); check("level_full_16", q, 32'd16);
    mm_rd(2'd2, q); check("status_full_ovf", q, 32'h0E);
    // Pop while full with a push attempt: pop only, push dropped
    sink_valid = 1'b1; sink_data = 16'h0EEE;
    mm_rd(2'd0, q); sink_valid = 1'b0;
    check("pop_while_full", q, 32'h0100);
    mm_rd(2'd1, q); check("level_15_after_full_pop", q, 32'd15);
    for (int i = 1; i < 16; i++) begin
      mm_rd(2'd0, q);
      check($sformatf("drain_%0d", i), q, 32'h0100 + 32'(i));
    end
    mm_rd(2'd2, q); check("status_empty_ovf", q, 32'h09);
    mm_wr(32'h2);
    mm_rd(2'd2, q); check("status_ovf_cleared", q, 32'h01);

    // Steady level 5 with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) push(DW'(16'h0200 + i));
    for (int k = 0; k < 20; k++) begin
      sink_valid = 1'b1;
      sink_data  = DW'(16'h0205 + k);
      mm_read    = 1'b1;
      mm_addr    = 2'd0;
      tick();
      check($sformatf("wrap_pop_%0d", k), mm_rdata, 32'h0200 + 32'(k));
    end
    idle_inputs();
    mm_rd(2'd1, q); check("level_stays_5", q, 32'd5);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) push(DW'(16'h0300 + i));
    mm_rd(2'd1, q); check("level_8_before_flush", q, 32'd8);
    sink_valid = 1'b1; sink_data = 16'h0AAA;
    mm_write = 1'b1; mm_addr = 2'd3; mm_wdata = 32'h1;
    #1;
    check("ready_low_during_flush", 32'(sink_ready), 32'd0);
    tick();
    idle_inputs();
    mm_rd(2'd1, q); check("level_0_after_flush", q, 32'd0);
    mm_rd(2'd2, q); check("status_empty_after_flush", q, 32'h01);

`ifdef FIFO_RESULTADOS_IRQ_EN
    mm_wr(32'h4);
    mm_rd(2'd2, q); check("status_irq_ena", q, 32'h21);
    for (int i = 0; i < 11; i++) push(DW'(16'h0400 + i));
    check("irq_low_level_11", 32'(irq), 32'd0);
    push(16'h040B);
    check("irq_low_at_level_12", 32'(irq), 32'd0);
    push(16'h040C);
    check("irq_high_one_cycle_later", 32'(irq), 32'd1);
    mm_rd(2'd1, q); check("level_13", q, 32'd13);
    sink_valid = 1'b1; sink_data = 16'h04FF;
    #2;
    reset_n = 1'b0;
    #1;
    check("irq_cleared_by_reset", 32'(irq), 32'd0);
`else
    mm_wr(32'h4);
    mm_rd(2'd2, q); check("status_bit5_ignored", q, 32'h01);
    for (int i = 0; i < 3; i++) push(DW'(16'h0400 + i));
    mm_rd(2'd1, q); check("level_3_before_reset", q, 32'd3);
    sink_valid = 1'b1; sink_data = 16'h04FF;
    #2;
    reset_n = 1'b0;
    #1;
`endif
    check("midreset_ready", 32'(sink_ready), 32'd0);
    check("midreset_rdata", mm_rdata, 32'd0);
    idle_inputs();
    @(negedge wrclock);
    reset_n = 1'b1;
    tick();
    mm_rd(2'd1, q); check("level_0_after_midreset", q, 32'd0);
    mm_rd(2'd2, q); check("status_after_midreset", q, 32'h01);
    mm_rd(2'd0, q); check("data_after_midreset", q, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
